// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 ALU issue controller.
// Holds the ALU opcode encodings, the status bit positions, the controller
// FSM state type and the latched request record.
// Optional feature macro used by the design: JAC_ILLEGAL_TRAP_EN.
package jac_pkg;

  localparam int unsigned DataW    = 8;
  localparam int unsigned OpW      = 5;
  localparam int unsigned ParamW   = 8;
  localparam int unsigned StatusW  = 6;
  localparam int unsigned RegAddrW = 2;

  localparam logic [OpW-1:0] Op_NOP = 5'd0;
  localparam logic [OpW-1:0] Op_ADD = 5'd1;
  localparam logic [OpW-1:0] Op_SUB = 5'd2;
  localparam logic [OpW-1:0] Op_AND = 5'd3;
  localparam logic [OpW-1:0] Op_OR  = 5'd4;
  localparam logic [OpW-1:0] Op_NOT = 5'd5;
  localparam logic [OpW-1:0] Op_XOR = 5'd6;
  localparam logic [OpW-1:0] Op_SHL = 5'd7;
  localparam logic [OpW-1:0] Op_SHR = 5'd8;
  localparam logic [OpW-1:0] Op_VAL = 5'd9;

  // Bit positions inside the ALU status word.
  localparam int unsigned StOverflow  = 0;
  localparam int unsigned StUnderflow = 1;
  localparam int unsigned StZero      = 2;
  localparam int unsigned StEqual     = 3;
  localparam int unsigned StGreater   = 4;
  localparam int unsigned StSmaller   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

  typedef struct packed {
    logic [OpW-1:0]      opcode;
    logic [RegAddrW-1:0] dst;
    logic [RegAddrW-1:0] src1;
    logic [RegAddrW-1:0] src2;
    logic [ParamW-1:0]   param;
  } req_t;

endpackage

// File: rtl/jac_alu_issue_if.sv
// Request/response handshake bundle between the decode stage (master) and
// the ALU issue controller (slave).
//   req_*  : operation request, valid/ready handshake, master -> slave
//   rsp_*  : result/status response, valid/ready handshake, slave -> master
//   rsp_error exists only when JAC_ILLEGAL_TRAP_EN is defined.
interface jac_alu_issue_if #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned NumStatusBits = 6,
  parameter int unsigned NumRegs       = 4
);
  localparam int unsigned AddrW = $clog2(NumRegs);

  logic                     req_valid;
  logic                     req_ready;
  logic [NumOpCodeBits-1:0] req_opcode;
  logic [AddrW-1:0]         req_dst;
  logic [AddrW-1:0]         req_src1;
  logic [AddrW-1:0]         req_src2;
  logic [ParamBits-1:0]     req_param;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DataWidth-1:0]     rsp_result;
  logic [NumStatusBits-1:0] rsp_status;
`ifdef JAC_ILLEGAL_TRAP_EN
  logic                     rsp_error;

  modport master (
    output req_valid, req_opcode, req_dst, req_src1, req_src2, req_param, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_status, rsp_error
  );
  modport slave (
    input  req_valid, req_opcode, req_dst, req_src1, req_src2, req_param, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_status, rsp_error
  );
`else
  modport master (
    output req_valid, req_opcode, req_dst, req_src1, req_src2, req_param, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_status
  );
  modport slave (
    input  req_valid, req_opcode, req_dst, req_src1, req_src2, req_param, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_status
  );
`endif
endinterface

// File: rtl/jac_regfile.sv
// Operand register file: NumRegs x DataWidth, synchronous reset to zero.
//   clk, rst           : clock, synchronous active-high reset (beats any write)
//   wb_en_i/addr/data  : ALU writeback, wins over a load to the same address
//   ld_en_i/addr/data  : host preload
//   rd1_*/rd2_*        : two combinational read ports
module jac_regfile #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned NumRegs   = 4,
  parameter int unsigned AddrW     = $clog2(NumRegs)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_en_i,
  input  logic [AddrW-1:0]     wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  input  logic                 ld_en_i,
  input  logic [AddrW-1:0]     ld_addr_i,
  input  logic [DataWidth-1:0] ld_data_i,
  input  logic [AddrW-1:0]     rd1_addr_i,
  output logic [DataWidth-1:0] rd1_data_o,
  input  logic [AddrW-1:0]     rd2_addr_i,
  output logic [DataWidth-1:0] rd2_data_o
);
  logic [DataWidth-1:0] regs_q [NumRegs];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (wb_en_i && wb_addr_i == AddrW'(i))      regs_q[i] <= wb_data_i;
        else if (ld_en_i && ld_addr_i == AddrW'(i)) regs_q[i] <= ld_data_i;
      end
    end
  end

  assign rd1_data_o = regs_q[rd1_addr_i];
  assign rd2_data_o = regs_q[rd2_addr_i];
endmodule

// File: rtl/jac_alu_issue.sv
// ALU issue controller for the Jac1-8 core.
// Accepts a request on bus (slave side), drives registered opcode/operands/
// param to the ALU, captures the combinational ALU result/status, writes the
// result back into the operand register file and returns the response.
//   clk, rst                      : clock, synchronous active-high reset
//   bus                           : request/response handshakes
//   alu_opcode/operand1/2/param   : registered ALU inputs
//   alu_result, alu_status        : combinational ALU outputs
//   ld_en, ld_addr, ld_data       : host preload of one register
// JAC_ILLEGAL_TRAP_EN: opcodes above VAL are issued as NOP, not written back,
// and flagged on bus.rsp_error with a zero status.
module jac_alu_issue
  import jac_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned NumStatusBits = 6,
  parameter int unsigned NumRegs       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  jac_alu_issue_if.slave             bus,
  output logic [NumOpCodeBits-1:0]   alu_opcode,
  output logic [DataWidth-1:0]       alu_operand1,
  output logic [DataWidth-1:0]       alu_operand2,
  output logic [ParamBits-1:0]       alu_param,
  input  logic [DataWidth-1:0]       alu_result,
  input  logic [NumStatusBits-1:0]   alu_status,
  input  logic                       ld_en,
  input  logic [$clog2(NumRegs)-1:0] ld_addr,
  input  logic [DataWidth-1:0]       ld_data
);
  localparam int unsigned AddrW = $clog2(NumRegs);

  state_e                   state_q;
  req_t                     req_q;
  logic                     req_ready_q;
  logic                     rsp_valid_q;
  logic [DataWidth-1:0]     rsp_result_q;
  logic [NumStatusBits-1:0] rsp_status_q;
  logic [NumOpCodeBits-1:0] alu_opcode_q;
  logic [DataWidth-1:0]     alu_operand1_q;
  logic [DataWidth-1:0]     alu_operand2_q;
  logic [ParamBits-1:0]     alu_param_q;
  logic [DataWidth-1:0]     rd1_data;
  logic [DataWidth-1:0]     rd2_data;
  logic                     illegal;
  logic                     wb_en;

`ifdef JAC_ILLEGAL_TRAP_EN
  logic                     rsp_error_q;
  assign illegal       = (req_q.opcode > Op_VAL);
  assign bus.rsp_error = rsp_error_q;
`else
  assign illegal = 1'b0;
`endif

  assign wb_en = (state_q == StCapture) && (req_q.opcode != Op_NOP) && !illegal;

  jac_regfile #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wb_en_i    (wb_en),
    .wb_addr_i  (req_q.dst),
    .wb_data_i  (alu_result),
    .ld_en_i    (ld_en),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .rd1_addr_i (req_q.src1),
    .rd1_data_o (rd1_data),
    .rd2_addr_i (req_q.src2),
    .rd2_data_o (rd2_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      req_q          <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_status_q   <= '0;
      alu_opcode_q   <= Op_NOP;
      alu_operand1_q <= '0;
      alu_operand2_q <= '0;
      alu_param_q    <= '0;
`ifdef JAC_ILLEGAL_TRAP_EN
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            req_q       <= '{opcode: bus.req_opcode, dst: bus.req_dst,
                             src1: bus.req_src1, src2: bus.req_src2,
                             param: bus.req_param};
            req_ready_q <= 1'b0;
`ifdef JAC_ILLEGAL_TRAP_EN
            rsp_error_q <= 1'b0;
`endif
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          // Operands are read here, not at accept, so a load landing on the
          // accepting edge is visible to this operation.
          alu_operand1_q <= rd1_data;
          alu_operand2_q <= rd2_data;
          alu_param_q    <= req_q.param;
          alu_opcode_q   <= illegal ? Op_NOP : req_q.opcode;
          state_q        <= StCapture;
        end
        StCapture: begin
          rsp_result_q <= alu_result;
          rsp_status_q <= illegal ? '0 : alu_status;
`ifdef JAC_ILLEGAL_TRAP_EN
          rsp_error_q  <= illegal;
`endif
          // Operands/param hold until the next issue; only the opcode parks at NOP.
          alu_opcode_q <= Op_NOP;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_status = rsp_status_q;
  assign alu_opcode     = alu_opcode_q;
  assign alu_operand1   = alu_operand1_q;
  assign alu_operand2   = alu_operand2_q;
  assign alu_param      = alu_param_q;
endmodule

// File: tb/tb_jac_alu_issue.sv
// Bench for jac_alu_issue: a behavioural ALU drives alu_result/alu_status,
// and a register-array model predicts every response.
// Honours JAC_ILLEGAL_TRAP_EN when defined.
module tb_jac_alu_issue;
  import jac_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] alu_opcode;
  logic [7:0] alu_operand1, alu_operand2, alu_param, alu_result;
  logic [5:0] alu_status;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] model [4];

  always #5 clk = ~clk;

  jac_alu_issue_if bus ();

  jac_alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_opcode   (alu_opcode),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_param    (alu_param),
    .alu_result   (alu_result),
    .alu_status   (alu_status),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data)
  );

  // ALU behaviour: {status, result}; status = {smaller, greater, equal, zero, underflow, overflow}
  function automatic logic [13:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] p);
    int s;
    logic [7:0] res;
    logic ov, un;
    ov = 1'b0; un = 1'b0; res = 8'd0;
    case (op)
      5'd1: begin s = int'(a) + int'(b); ov = (s > 255); res = 8'(s % 256); end
      5'd2: begin s = int'(a) - int'(b); un = (s < 0); res = 8'((s + 256) % 256); end
      5'd3: res = a & b;
      5'd4: res = a | b;
      5'd5: res = ~a;
      5'd6: res = a ^ b;
      5'd7: res = (p > 8'd7) ? 8'd0 : 8'(a << p);
      5'd8: res = (p > 8'd7) ? 8'd0 : (a >> p);
      5'd9: res = p;
      default: res = 8'd0;
    endcase
    return {a < b, a > b, a == b, res == 8'd0, un, ov, res};
  endfunction

  assign {alu_status, alu_result} = alu_fn(alu_opcode, alu_operand1, alu_operand2, alu_param);

  function automatic bit is_illegal(input logic [4:0] op);
`ifdef JAC_ILLEGAL_TRAP_EN
    return op > 5'd9;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    model[a] = d;
    #1 ld_en = 1'b0;
  endtask

  // One full transaction. ld_stage: 0 none, 1 load on accept edge,
  // 2 load on issue edge, 3 load on capture edge.
  task automatic issue(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [7:0] p, input int stall,
                       input bit keep_valid, input int ld_stage, input logic [1:0] la,
                       input logic [7:0] ldv, output logic [7:0] r_res, output logic [5:0] r_st);
    logic [7:0]  a, b;
    logic [4:0]  eop;
    logic [13:0] e;
    logic [5:0]  est;
    bit          ill;
    ill = is_illegal(op);
    eop = ill ? 5'd0 : op;
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_dst = dst;
    bus.req_src1 = s1; bus.req_src2 = s2; bus.req_param = p; bus.rsp_ready = 1'b1;
    if (ld_stage == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
    @(posedge clk);
    if (ld_stage == 1) model[la] = ldv;
    #1 ld_en = 1'b0;
    if (!keep_valid) bus.req_valid = 1'b0;
    a = model[s1]; b = model[s2];
    e = alu_fn(eop, a, b, p);
    est = ill ? 6'd0 : e[13:8];
    @(negedge clk);
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    check("rsp_valid_issue", 32'(bus.rsp_valid), 32'd0);
`ifdef JAC_ILLEGAL_TRAP_EN
    check("rsp_error_clear", 32'(bus.rsp_error), 32'd0);
`endif
    bus.rsp_ready = (stall == 0);
    if (ld_stage == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
    @(posedge clk);
    if (ld_stage == 2) model[la] = ldv;
    #1 ld_en = 1'b0;
    @(negedge clk);
    check("alu_opcode", 32'(alu_opcode), 32'(eop));
    check("alu_operand1", 32'(alu_operand1), 32'(a));
    check("alu_operand2", 32'(alu_operand2), 32'(b));
    check("alu_param", 32'(alu_param), 32'(p));
    check("rsp_valid_capture", 32'(bus.rsp_valid), 32'd0);
    if (ld_stage == 3) begin ld_en = 1'b1; ld_addr = la; ld_data = ldv; end
    @(posedge clk);
    if (ld_stage == 3) model[la] = ldv;
    if (!ill && eop != 5'd0) model[dst] = e[7:0];
    #1 ld_en = 1'b0;
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_result", 32'(bus.rsp_result), 32'(e[7:0]));
    check("rsp_status", 32'(bus.rsp_status), 32'(est));
    check("alu_opcode_nop", 32'(alu_opcode), 32'd0);
`ifdef JAC_ILLEGAL_TRAP_EN
    check("rsp_error", 32'(bus.rsp_error), 32'(ill));
`endif
    r_res = bus.rsp_result;
    r_st  = bus.rsp_status;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_result", 32'(bus.rsp_result), 32'(e[7:0]));
      check("stall_status", 32'(bus.rsp_status), 32'(est));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_done", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] res;
    logic [5:0] st;
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_dst = '0; bus.req_src1 = '0;
    bus.req_src2 = '0; bus.req_param = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_operand1", 32'(alu_operand1), 32'd0);
    check("rst_alu_operand2", 32'(alu_operand2), 32'd0);
    check("rst_alu_param", 32'(alu_param), 32'd0);
`ifdef JAC_ILLEGAL_TRAP_EN
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
`endif

    // ADD 1+3, then read r0 back
    do_load(2'd1, 8'd1); do_load(2'd2, 8'd3);
    issue(5'd1, 2'd0, 2'd1, 2'd2, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("add_small_res", 32'(res), 32'd4);
    check("add_small_st", 32'(st), 32'b100000);
    issue(5'd4, 2'd3, 2'd0, 2'd0, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("r0_readback", 32'(res), 32'd4);

    // ADD with carry out
    do_load(2'd1, 8'd255); do_load(2'd2, 8'd2);
    issue(5'd1, 2'd0, 2'd1, 2'd2, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("add_ovf_res", 32'(res), 32'd1);
    check("add_ovf_st", 32'(st), 32'b010001);

    // SUB with borrow, SHL by 3
    do_load(2'd1, 8'd14); do_load(2'd2, 8'd15);
    issue(5'd2, 2'd0, 2'd1, 2'd2, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("sub_unf_res", 32'(res), 32'd255);
    check("sub_unf_st", 32'(st), 32'b100010);
    issue(5'd7, 2'd3, 2'd1, 2'd0, 8'd3, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("shl_res", 32'(res), 32'h70);

    // Back-pressure: rsp_ready low 5 cycles, next request already waiting
    issue(5'd1, 2'd0, 2'd1, 2'd2, 8'd0, 5, 1'b1, 0, 2'd0, 8'd0, res, st);
    issue(5'd1, 2'd0, 2'd1, 2'd2, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("held_req_res", 32'(res), 32'd29);

    // Load timing against the operation in flight
    do_load(2'd1, 8'd5); do_load(2'd2, 8'd6);
    issue(5'd1, 2'd3, 2'd1, 2'd2, 8'd0, 0, 1'b0, 2, 2'd1, 8'd100, res, st);
    check("late_load_ignored", 32'(res), 32'd11);
    issue(5'd4, 2'd0, 2'd1, 2'd1, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("late_load_committed", 32'(res), 32'd100);
    issue(5'd1, 2'd1, 2'd1, 2'd2, 8'd0, 0, 1'b0, 3, 2'd1, 8'd50, res, st);
    issue(5'd4, 2'd0, 2'd1, 2'd1, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("wb_beats_load", 32'(res), 32'd106);
    issue(5'd1, 2'd0, 2'd2, 2'd2, 8'd0, 0, 1'b0, 1, 2'd2, 8'd20, res, st);
    check("accept_edge_load", 32'(res), 32'd40);

    // Reset during CAPTURE of a write to r2
    do_load(2'd2, 8'd7);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = 5'd1; bus.req_dst = 2'd2;
    bus.req_src1 = 2'd2; bus.req_src2 = 2'd2; bus.req_param = 8'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'd0;
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    issue(5'd4, 2'd3, 2'd2, 2'd2, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("rst_mid_r2_zero", 32'(res), 32'd0);

`ifdef JAC_ILLEGAL_TRAP_EN
    do_load(2'd1, 8'd9);
    issue(5'b1_0000, 2'd1, 2'd1, 2'd1, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("illegal_status", 32'(st), 32'd0);
    check("illegal_error_held", 32'(bus.rsp_error), 32'd1);
    issue(5'd4, 2'd2, 2'd1, 2'd1, 8'd0, 0, 1'b0, 0, 2'd0, 8'd0, res, st);
    check("illegal_no_wb", 32'(res), 32'd9);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 2) == 0) do_load(2'($urandom_range(0, 3)), 8'($urandom));
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
      issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 9)), $urandom_range(0, 2), 1'b0, $urandom_range(0, 3),
            2'($urandom_range(0, 3)), 8'($urandom), res, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
